// File: rtl/v200_sim_pkg.sv
// Shared types for the V200 power-on sequencer.
//   seq_state_t : sequencer state encoding
//   FIN_*       : finish_code values reported to the host
package v200_sim_pkg;

  typedef enum logic [2:0] {RESET, HOLD, RUN, DONE, HALT} seq_state_t;

  localparam logic [1:0] FIN_NONE    = 2'b00;
  localparam logic [1:0] FIN_PASS    = 2'b01;
  localparam logic [1:0] FIN_TIMEOUT = 2'b10;

endpackage

// File: rtl/por_sequencer_if.sv
// Core/host control bundle of the power-on sequencer.
//   heartbeat   : core activity pulse, clears the watchdog
//   sw_finish   : core reports test complete (pass)
//   finish_req  : end-of-run request to the host
//   finish_code : reason for the end of run
//   finish_ack  : host acknowledge of finish_req
// master = sequencer side, slave = core/host side.
interface por_sequencer_if;

  logic       heartbeat;
  logic       sw_finish;
  logic       finish_req;
  logic [1:0] finish_code;
  logic       finish_ack;

  modport master (
    input  heartbeat,
    input  sw_finish,
    input  finish_ack,
    output finish_req,
    output finish_code
  );

  modport slave (
    output heartbeat,
    output sw_finish,
    output finish_ack,
    input  finish_req,
    input  finish_code
  );

endinterface

// File: rtl/reset_sync.sv
// Reset-release synchroniser: asynchronous assertion, release after STAGES
// rising edges of clk.
//   clk        : clock
//   rst_n      : asynchronous active-low reset in
//   rst_sync_n : synchronised reset release (high = released)
// The chain shifts in a constant 1, so the only path into the first flop
// is its reset; nothing asynchronous reaches the data pins.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/por_sequencer.sv
// Power-on sequencer for the V200 core: synchronises reset release,
// stretches core reset, generates CLKEN, counts run cycles, runs a hang
// watchdog and reports end-of-run to the host via finish_req/finish_ack.
//   CLK2X            : clock
//   NATIVEPORRESET_n : asynchronous active-low reset
//   hs               : heartbeat/sw_finish/finish handshake bundle
//   CLKEN            : core clock enable
//   core_rst_n       : core reset (low unless in RUN)
//   cycle_count      : enabled RUN cycles, saturating
module por_sequencer
  import v200_sim_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CLKEN_DIV   = 1,
  parameter int CNT_W       = 32,
  parameter int WDOG_LIMIT  = 12000
) (
  input  logic             CLK2X,
  input  logic             NATIVEPORRESET_n,
  por_sequencer_if.master  hs,
  output logic             CLKEN,
  output logic             core_rst_n,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DIV_W  = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKEN_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  WDOG_LIM  = CNT_W'(WDOG_LIMIT);

  seq_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [DIV_W-1:0]  div_q,   div_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [CNT_W-1:0]  wdog_q,  wdog_d;
  logic [1:0]        code_q,  code_d;
  logic              rst_sync_n;
  logic              clken;
  logic              wdog_hit;

  reset_sync #(.STAGES(SYNC_STAGES)) u_reset_sync (
    .clk        (CLK2X),
    .rst_n      (NATIVEPORRESET_n),
    .rst_sync_n (rst_sync_n)
  );

  assign clken = ((state_q == HOLD) || (state_q == RUN)) && (div_q == '0);

  // A heartbeat in the limit cycle resets the watchdog instead of firing it.
  assign wdog_hit = (WDOG_LIMIT != 0) && clken && !hs.heartbeat &&
                    ((wdog_q + CNT_ONE) == WDOG_LIM);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    code_d  = code_q;

    // Divider free-runs through HOLD and RUN; it is only cleared on HOLD entry.
    if ((state_q == HOLD) || (state_q == RUN)) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
    end

    case (state_q)
      RESET: begin
        if (rst_sync_n) begin
          state_d = HOLD;
          hold_d  = '0;
          div_d   = '0;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      RUN: begin
        if (clken && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (hs.heartbeat) begin
          wdog_d = '0;
        end else if (clken && (wdog_q != CNT_MAX)) begin
          wdog_d = wdog_q + CNT_ONE;
        end
        // sw_finish has priority over a coincident timeout.
        if (hs.sw_finish) begin
          state_d = DONE;
          code_d  = FIN_PASS;
        end else if (wdog_hit) begin
          state_d = DONE;
          code_d  = FIN_TIMEOUT;
        end
      end
      DONE: begin
        if (hs.finish_ack) begin
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  always_ff @(posedge CLK2X or negedge NATIVEPORRESET_n) begin
    if (!NATIVEPORRESET_n) begin
      state_q <= RESET;
      hold_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      code_q  <= FIN_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      code_q  <= code_d;
    end
  end

  // Outputs decode straight from registers, so reset forces them low at once.
  assign CLKEN          = clken;
  assign core_rst_n     = (state_q == RUN);
  assign cycle_count    = cnt_q;
  assign hs.finish_req  = (state_q == DONE);
  assign hs.finish_code = code_q;

endmodule

// File: tb/tb_por_sequencer.sv
module tb_por_sequencer;

  // Instance 0: default timing, short watchdog. Instance 1: divided CLKEN, 8-bit counter, no watchdog.
  localparam int S0 = 2, H0 = 16, D0 = 1, C0 = 32, W0 = 100;
  localparam int S1 = 3, H1 = 5,  D1 = 3, C1 = 8,  W1 = 0;
  localparam bit [5:0] PAT = 6'b001001;   // CLKEN from HOLD entry: 1,0,0,1,0,0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn, hb, swf, ack;

  por_sequencer_if if0 ();
  por_sequencer_if if1 ();
  assign if0.heartbeat  = hb[0];
  assign if0.sw_finish  = swf[0];
  assign if0.finish_ack = ack[0];
  assign if1.heartbeat  = hb[1];
  assign if1.sw_finish  = swf[1];
  assign if1.finish_ack = ack[1];

  logic          clken0, core0, clken1, core1;
  logic [C0-1:0] cc0;
  logic [C1-1:0] cc1;

  por_sequencer #(.SYNC_STAGES(S0), .HOLD_CYCLES(H0), .CLKEN_DIV(D0), .CNT_W(C0), .WDOG_LIMIT(W0)) dut0 (
    .CLK2X(clk), .NATIVEPORRESET_n(rstn[0]), .hs(if0),
    .CLKEN(clken0), .core_rst_n(core0), .cycle_count(cc0));

  por_sequencer #(.SYNC_STAGES(S1), .HOLD_CYCLES(H1), .CLKEN_DIV(D1), .CNT_W(C1), .WDOG_LIMIT(W1)) dut1 (
    .CLK2X(clk), .NATIVEPORRESET_n(rstn[1]), .hs(if1),
    .CLKEN(clken1), .core_rst_n(core1), .cycle_count(cc1));

  int checks = 0;
  int failures = 0;

  function automatic int p_s(int i); return (i == 0) ? S0 : S1; endfunction
  function automatic int p_h(int i); return (i == 0) ? H0 : H1; endfunction
  function automatic int p_d(int i); return (i == 0) ? D0 : D1; endfunction
  function automatic int p_w(int i); return (i == 0) ? W0 : W1; endfunction
  function automatic longint p_max(int i); return (i == 0) ? ((64'd1 << C0) - 1) : ((64'd1 << C1) - 1); endfunction

  function automatic logic get_clken(int i); return (i == 0) ? clken0 : clken1; endfunction
  function automatic logic get_core(int i);  return (i == 0) ? core0 : core1; endfunction
  function automatic logic get_req(int i);   return (i == 0) ? if0.finish_req : if1.finish_req; endfunction
  function automatic logic [1:0] get_code(int i); return (i == 0) ? if0.finish_code : if1.finish_code; endfunction
  function automatic logic [63:0] get_cc(int i); return (i == 0) ? 64'(cc0) : 64'(cc1); endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: everything is derived from the number of edges since
  // release plus a few event flags, not from a state machine.
  int        m_e     [2];
  longint    m_cnt   [2];
  longint    m_since [2];
  bit        m_done  [2];
  bit        m_halt  [2];
  logic [1:0] m_code [2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rstn[i]) begin
        m_e[i] = 0; m_cnt[i] = 0; m_since[i] = 0;
        m_done[i] = 1'b0; m_halt[i] = 1'b0; m_code[i] = 2'b00;
      end else begin
        bit run_cyc;
        bit en;
        run_cyc = (m_e[i] >= p_s(i) + 1 + p_h(i)) && !m_done[i];
        en = (m_e[i] >= p_s(i) + 1) && !m_done[i] && (((m_e[i] - (p_s(i) + 1)) % p_d(i)) == 0);
        if (run_cyc) begin
          if (en && (m_cnt[i] < p_max(i))) m_cnt[i]++;
          if (swf[i]) begin
            m_done[i] = 1'b1; m_code[i] = 2'b01;
          end else begin
            if (hb[i]) m_since[i] = 0;
            else if (en) m_since[i]++;
            if ((p_w(i) != 0) && (m_since[i] == p_w(i))) begin
              m_done[i] = 1'b1; m_code[i] = 2'b10;
            end
          end
        end else if (m_done[i] && !m_halt[i] && ack[i]) begin
          m_halt[i] = 1'b1;
        end
        m_e[i]++;
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      bit live;
      bit exp_en;
      live   = rstn[i] && !m_done[i];
      exp_en = live && (m_e[i] >= p_s(i) + 1) && (((m_e[i] - (p_s(i) + 1)) % p_d(i)) == 0);
      check($sformatf("cyc_clken%0d", i), 64'(get_clken(i)), 64'(exp_en));
      check($sformatf("cyc_core%0d", i),  64'(get_core(i)),  64'(live && (m_e[i] >= p_s(i) + 1 + p_h(i))));
      check($sformatf("cyc_req%0d", i),   64'(get_req(i)),   64'(rstn[i] && m_done[i] && !m_halt[i]));
      check($sformatf("cyc_code%0d", i),  64'(get_code(i)),  64'(m_code[i]));
      check($sformatf("cyc_count%0d", i), get_cc(i),         64'(m_cnt[i]));
    end
  endtask

  // One cycle: update the model on the edge, compare 3 time units later, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #3;
    compare();
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic release_wait(int i, int exp_edges, string nm);
    int n;
    n = 0;
    rstn[i] = 1'b1;
    while (!get_core(i) && n < 200) begin
      tick();
      n++;
    end
    check(nm, 64'(n), 64'(exp_edges));
  endtask

  task automatic async_reset(int i, string nm);
    #2;
    rstn[i] = 1'b0;
    #1;
    check({nm, "_core"},  64'(get_core(i)),  64'd0);
    check({nm, "_clken"}, 64'(get_clken(i)), 64'd0);
    check({nm, "_req"},   64'(get_req(i)),   64'd0);
    check({nm, "_code"},  64'(get_code(i)),  64'd0);
    check({nm, "_count"}, get_cc(i),         64'd0);
    ticks(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int next_hb;
    int hbp;
    for (int i = 0; i < 2; i++) begin
      m_e[i] = 0; m_cnt[i] = 0; m_since[i] = 0;
      m_done[i] = 1'b0; m_halt[i] = 1'b0; m_code[i] = 2'b00;
    end
    rstn = 2'b11; hb = '0; swf = '0; ack = '0;
    #1 rstn = 2'b00;
    #1;
    check("rst_core0", 64'(core0), 64'd0);
    check("rst_req0",  64'(if0.finish_req), 64'd0);
    check("rst_cnt1",  get_cc(1), 64'd0);
    check("rst_clken1", 64'(clken1), 64'd0);
    @(negedge clk);
    ticks(3);

    // Default release timing, random heartbeats, sw_finish at RUN cycle 500.
    release_wait(0, 19, "t1_core_rise_edges");
    check("t1_clken_run", 64'(clken0), 64'd1);
    next_hb = $urandom_range(20, 60);
    for (int c = 1; c <= 500; c++) begin
      hb[0]  = (c == next_hb);
      if (c == next_hb) next_hb = c + $urandom_range(20, 60);
      swf[0] = (c == 500);
      tick();
    end
    hb[0] = 1'b0; swf[0] = 1'b0;
    check("t4_pass_code", 64'(if0.finish_code), 64'd1);
    check("t4_pass_count", get_cc(0), 64'd500);
    check("t4_pass_req", 64'(if0.finish_req), 64'd1);
    ticks($urandom_range(0, 6));
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    check("t4_req_after_ack", 64'(if0.finish_req), 64'd0);
    check("t4_code_kept", 64'(if0.finish_code), 64'd1);
    ticks(3);

    // Watchdog timeout after 100 RUN cycles, ack on DONE cycle 5.
    async_reset(0, "t3_pre");
    release_wait(0, 19, "t3_core_rise_edges");
    n = 0;
    while (!if0.finish_req && n < 300) begin tick(); n++; end
    check("t3_timeout_cycles", 64'(n), 64'd100);
    check("t3_timeout_code", 64'(if0.finish_code), 64'd2);
    check("t3_timeout_count", get_cc(0), 64'd100);
    ticks(4);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    check("t3_req_fall", 64'(if0.finish_req), 64'd0);
    check("t3_count_kept", get_cc(0), 64'd100);

    // sw_finish coincident with the watchdog limit.
    async_reset(0, "t4_pre");
    release_wait(0, 19, "t4_core_rise_edges");
    ticks(99);
    swf[0] = 1'b1; tick(); swf[0] = 1'b0;
    check("t4_sw_beats_wdog", 64'(if0.finish_code), 64'd1);
    check("t4_sw_count", get_cc(0), 64'd100);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;

    // Heartbeat in the limit cycle prevents the timeout.
    async_reset(0, "t4b_pre");
    release_wait(0, 19, "t4b_core_rise_edges");
    ticks(99);
    hb[0] = 1'b1; tick(); hb[0] = 1'b0;
    check("t4_hb_at_limit", 64'(if0.finish_req), 64'd0);
    ticks(50);
    check("t4_hb_still_run", 64'(if0.finish_req), 64'd0);
    check("t4_hb_count", get_cc(0), 64'd150);

    // Reset mid-RUN and mid-DONE.
    async_reset(0, "t5_run");
    release_wait(0, 19, "t5_rerelease_edges");
    ticks($urandom_range(5, 40));
    swf[0] = 1'b1; tick(); swf[0] = 1'b0;
    check("t5_in_done", 64'(if0.finish_req), 64'd1);
    ticks(2);
    async_reset(0, "t5_done");

    // Random soak on instance 0.
    for (int r = 0; r < 4; r++) begin
      rstn[0] = 1'b1;
      hbp = $urandom_range(0, 6);
      for (int c = 0; c < 400; c++) begin
        hb[0]  = ($urandom_range(0, 99) < hbp);
        swf[0] = ($urandom_range(0, 599) == 0);
        ack[0] = ($urandom_range(0, 3) == 0);
        tick();
      end
      hb[0] = 1'b0; swf[0] = 1'b0; ack[0] = 1'b0;
      async_reset(0, "soak");
    end

    // Divided CLKEN, saturation, early ack on instance 1.
    ack[1] = 1'b1;
    rstn[1] = 1'b1;
    n = 0;
    while (!clken1 && n < 50) begin tick(); n++; end
    check("t2_hold_entry_edges", 64'(n), 64'(S1 + 1));
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_clken_pat%0d", k), 64'(clken1), 64'(PAT[k]));
      tick();
    end
    n = 0;
    while (get_cc(1) != 64'd255 && n < 1500) begin
      hb[1] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    hb[1] = 1'b0;
    check("t6_saturate", get_cc(1), 64'd255);
    ticks(40);
    check("t6_sat_hold", get_cc(1), 64'd255);
    check("t6_no_timeout", 64'(if1.finish_req), 64'd0);
    swf[1] = 1'b1; tick(); swf[1] = 1'b0;
    check("t6_req_rise", 64'(if1.finish_req), 64'd1);
    tick();
    check("t6_early_ack_halt", 64'(if1.finish_req), 64'd0);
    check("t6_code_kept", 64'(if1.finish_code), 64'd1);
    check("t6_count_kept", get_cc(1), 64'd255);
    ack[1] = 1'b0;
    ticks(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
